dlx_mem_arb: RTL

DLX_MEM_ARB -- requirements
Module: dlx_mem_arb

---
 rtl/dlx_mem_arb_pkg.sv | 16 +
 rtl/dlx_mem_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dlx_mem_arb_pkg.sv
// Shared DLX globals: machine word / address types and the memory arbiter
// FSM state encoding. Imported by dlx_mem_arb.
package dlx_mem_arb_pkg;

  typedef logic [31:0] dlx_word;
  typedef logic [31:0] dlx_address;

  localparam int unsigned DLX_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IC_BURST = 2'd1,
    ST_DC_ACC   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dlx_mem_arb.sv
// dlx_mem_arb - shares one memory port between the I-cache refill engine and
// the D-side load/store path.
//   clk, rst (sync, active-low)
//   ic_req/ic_addr       -> line refill of BURST_LEN words; ic_rdata/ic_rvalid per
//                           beat, ic_done with the last beat
//   dc_req/dc_we/dc_addr/dc_wdata -> single access; dc_rdata/dc_done
//   dc_wait/if_stall     -> combinational pipeline holds
//   mem_*                -> shared memory port, all outputs registered
// Build option: DLX_MEM_ARB_RR_EN selects round-robin between simultaneous
// requests; otherwise dc_req has fixed priority.
module dlx_mem_arb
  import dlx_mem_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ic_req,
  input  dlx_address ic_addr,
  output dlx_word    ic_rdata,
  output logic       ic_rvalid,
  output logic       ic_done,
  input  logic       dc_req,
  input  logic       dc_we,
  input  dlx_address dc_addr,
  input  dlx_word    dc_wdata,
  output dlx_word    dc_rdata,
  output logic       dc_done,
  output logic       dc_wait,
  output logic       if_stall,
  output logic       mem_req,
  output logic       mem_we,
  output dlx_address mem_addr,
  output dlx_word    mem_wdata,
  input  dlx_word    mem_rdata,
  input  logic       mem_ack
);

  localparam int unsigned     BEAT_W    = $clog2(BURST_LEN);
  localparam int unsigned     LINE_LSB  = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam dlx_address      LINE_MASK = ~((32'd1 << LINE_LSB) - 32'd1);

  arb_state_t        r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  dlx_address        r_mem_addr, w_mem_addr_nxt;
  dlx_word           r_mem_wdata, w_mem_wdata_nxt;
  dlx_word           r_ic_rdata, w_ic_rdata_nxt;
  logic              r_ic_rvalid, w_ic_rvalid_nxt;
  logic              r_ic_done, w_ic_done_nxt;
  dlx_word           r_dc_rdata, w_dc_rdata_nxt;
  logic              r_dc_done, w_dc_done_nxt;

  // A requester whose done pulse is high this cycle is still holding its
  // request only because the pipeline has not seen the pulse yet.
  logic w_ic_cand, w_dc_cand, w_pick_dc;
  assign w_ic_cand = ic_req & ~r_ic_done;
  assign w_dc_cand = dc_req & ~r_dc_done;

`ifdef DLX_MEM_ARB_RR_EN
  logic r_last_ic, w_last_ic_nxt;
  assign w_pick_dc = w_dc_cand & (~w_ic_cand | r_last_ic);

  always_comb begin
    w_last_ic_nxt = r_last_ic;
    if (r_state == ST_IDLE) begin
      if (w_pick_dc)      w_last_ic_nxt = 1'b0;
      else if (w_ic_cand) w_last_ic_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_last_ic <= 1'b1;
    else      r_last_ic <= w_last_ic_nxt;
  end
`else
  assign w_pick_dc = w_dc_cand;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_ic_rdata_nxt  = r_ic_rdata;
    w_ic_rvalid_nxt = 1'b0;
    w_ic_done_nxt   = 1'b0;
    w_dc_rdata_nxt  = r_dc_rdata;
    w_dc_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_dc) begin
          w_state_nxt     = ST_DC_ACC;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = dc_we;
          w_mem_addr_nxt  = dc_addr;
          w_mem_wdata_nxt = dc_wdata;
        end else if (w_ic_cand) begin
          w_state_nxt     = ST_IC_BURST;
          w_beat_nxt      = '0;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = ic_addr & LINE_MASK;
        end
      end
      ST_IC_BURST: begin
        if (mem_ack) begin
          w_ic_rdata_nxt  = mem_rdata;
          w_ic_rvalid_nxt = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_ic_done_nxt = 1'b1;
            w_mem_req_nxt = 1'b0;
            w_beat_nxt    = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_beat_nxt     = r_beat + BEAT_W'(1);
            w_mem_addr_nxt = r_mem_addr + DLX_WORD_BYTES;
          end
        end
      end
      ST_DC_ACC: begin
        if (mem_ack) begin
          if (!r_mem_we) w_dc_rdata_nxt = mem_rdata;
          w_dc_done_nxt = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset abandons any transaction in flight: no done pulse, mem_req drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_rdata  <= '0;
      r_ic_rvalid <= 1'b0;
      r_ic_done   <= 1'b0;
      r_dc_rdata  <= '0;
      r_dc_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_ic_rdata  <= w_ic_rdata_nxt;
      r_ic_rvalid <= w_ic_rvalid_nxt;
      r_ic_done   <= w_ic_done_nxt;
      r_dc_rdata  <= w_dc_rdata_nxt;
      r_dc_done   <= w_dc_done_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ic_rdata  = r_ic_rdata;
  assign ic_rvalid = r_ic_rvalid;
  assign ic_done   = r_ic_done;
  assign dc_rdata  = r_dc_rdata;
  assign dc_done   = r_dc_done;
  assign dc_wait   = dc_req & ~r_dc_done;
  assign if_stall  = ic_req & ~r_ic_done;

endmodule
